// File: rtl/sha256_iter_ctrl.sv
// Iteration sequencer for an external single-round SHA-256 datapath: 64 rounds per block, digest add, valid/ready output.
// Optional multi-block chaining via hash_reg is enabled by defining SHA256_CHAIN_EN.
module sha256_iter_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic [255:0] rnd_state_in,
  output logic [31:0]  rnd_kt,
  output logic [511:0] rnd_msg_in,
  input  logic [255:0] rnd_state_out,
  input  logic [511:0] rnd_msg_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 1);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [1:0]   r_state;
  logic [5:0]   r_cnt;
  logic [511:0] r_blk;
  logic [255:0] r_base;
  logic [255:0] r_digest;
  logic         r_out_valid;
  logic [255:0] w_base_next;
  logic [255:0] w_sum;

`ifdef SHA256_CHAIN_EN
  logic [255:0] r_hash;

  assign w_base_next = in_first ? IV : r_hash;

  // Reset restores IV so an aborted message never leaks into the next chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hash <= IV;
    end else if (r_state == S_ADD) begin
      r_hash <= w_sum;
    end
  end
`else
  logic w_unused_first;

  assign w_unused_first = in_first;
  assign w_base_next    = IV;
`endif

  // Per-word modular add; carries never cross 32-bit word boundaries.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i*32 +: 32] = r_base[i*32 +: 32] + rnd_state_out[i*32 +: 32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_blk       <= '0;
      r_base      <= '0;
      r_digest    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_blk   <= in_block;
            r_base  <= w_base_next;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= S_ADD;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_ADD: begin
          r_digest    <= w_sum;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset pulse.
  assign in_ready   = rst_n & (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_digest = r_digest;

  // Round 0 takes the captured block and base; later rounds loop the datapath result back.
  assign rnd_state_in = (r_cnt == 6'd0) ? r_base : rnd_state_out;
  assign rnd_msg_in   = (r_cnt == 6'd0) ? r_blk  : rnd_msg_out;
  assign rnd_kt       = K_ROM[r_cnt];

endmodule

// File: tb/tb_sha256_iter_ctrl.sv
// Bench for sha256_iter_ctrl: a one-round datapath model closes the loop; digests are checked against known answers and a full SHA-256 compression model.
`timescale 1ns/1ps
module tb_sha256_iter_ctrl;

  localparam int ROUNDS = 64;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_block = '0;
  logic         in_first = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_digest;
  logic [255:0] rnd_state_in;
  logic [31:0]  rnd_kt;
  logic [511:0] rnd_msg_in;
  logic [255:0] rnd_state_out;
  logic [511:0] rnd_msg_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_iter_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_block      (in_block),
    .in_first      (in_first),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_digest    (out_digest),
    .rnd_state_in  (rnd_state_in),
    .rnd_kt        (rnd_kt),
    .rnd_msg_in    (rnd_msg_in),
    .rnd_state_out (rnd_state_out),
    .rnd_msg_out   (rnd_msg_out)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  // External single-round datapath: one registered round plus a sliding 16-word schedule window.
  function automatic logic [255:0] dp_round(input logic [255:0] s, input logic [31:0] kt, input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + kt + wt;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [511:0] dp_sched(input logic [511:0] m);
    logic [31:0] nw;
    nw = ssig1(m[63:32]) + m[223:192] + ssig0(m[479:448]) + m[511:480];
    return {m[479:0], nw};
  endfunction

  always @(posedge clk) begin
    rnd_state_out <= dp_round(rnd_state_in, rnd_kt, rnd_msg_in[511:480]);
    rnd_msg_out   <= dp_sched(rnd_msg_in);
  end

  // Reference: whole-block compression with the full 64-word schedule expanded up front.
  function automatic logic [255:0] ref_compress(input logic [255:0] h_in, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = h_in[255 - 32*i -: 32];
    for (int t = 0; t < ROUNDS; t++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = h_in[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  // Offers a block, waits for acceptance and for out_valid; lat counts edges from accept to out_valid.
  task automatic send_block(input logic [511:0] blk, input logic first, input logic keep_valid,
                            output logic [255:0] dig, output int lat, output logic ok);
    int n;
    ok = 1'b1;
    dig = '0;
    lat = 0;
    in_block = blk;
    in_first = first;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++; ok = 1'b0;
      $display("FAIL accept_timeout in_ready=%b after %0d cycles", in_ready, n);
      return;
    end
    @(posedge clk); #1;
    if (!keep_valid) begin
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) in_block[i*32 +: 32] = $urandom();
      in_first = 1'($urandom_range(0, 1));
    end
    while (!out_valid && lat < 500) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++; ok = 1'b0;
      $display("FAIL out_valid_timeout out_valid=%b after %0d cycles", out_valid, lat);
      return;
    end
    dig = out_digest;
  endtask

  task automatic release_digest(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release out_valid=%b in_ready=%b expected 0 and 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_digest !== 256'h0) begin
      errors++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b digest=%h expected 0 0 0", in_ready, out_valid, out_digest);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_known_answers();
    logic [255:0] dig;
    int lat;
    logic ok;
    send_block(BLK_ABC, 1'b1, 1'b0, dig, lat, ok);
    if (ok) begin
      checks++;
      if (dig !== D_ABC) begin errors++; $display("FAIL abc_digest got %h expected %h", dig, D_ABC); end
      checks++;
      if (lat !== ROUNDS + 1) begin errors++; $display("FAIL abc_latency got %0d expected %0d", lat, ROUNDS + 1); end
      release_digest("abc");
    end
    send_block(BLK_EMPTY, 1'b1, 1'b0, dig, lat, ok);
    if (ok) begin
      checks++;
      if (dig !== D_EMPTY) begin errors++; $display("FAIL empty_digest got %h expected %h", dig, D_EMPTY); end
      release_digest("empty");
    end
  endtask

  task automatic test_chain();
    logic [255:0] dig, exp1;
    int lat;
    logic ok;
    exp1 = ref_compress(IV, BLK_TWO1);
    send_block(BLK_TWO1, 1'b1, 1'b0, dig, lat, ok);
    if (ok) begin
      checks++;
      if (dig !== exp1) begin errors++; $display("FAIL chain_blk1 got %h expected %h", dig, exp1); end
      release_digest("chain1");
    end
    send_block(BLK_TWO2, 1'b0, 1'b0, dig, lat, ok);
    if (ok) begin
`ifdef SHA256_CHAIN_EN
      checks++;
      if (dig !== D_TWO) begin errors++; $display("FAIL chain_blk2 got %h expected %h", dig, D_TWO); end
`else
      checks++;
      if (dig === D_TWO || dig !== ref_compress(IV, BLK_TWO2)) begin
        errors++;
        $display("FAIL standalone_blk2 got %h expected %h", dig, ref_compress(IV, BLK_TWO2));
      end
`endif
      release_digest("chain2");
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] dig;
    int lat;
    logic ok;
    send_block(BLK_ABC, 1'b1, 1'b0, dig, lat, ok);
    if (ok) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_digest !== D_ABC) begin
          errors++;
          $display("FAIL backpressure_hold cycle %0d out_valid=%b in_ready=%b digest=%h expected 1 0 %h",
                   i, out_valid, in_ready, out_digest, D_ABC);
        end
      end
      release_digest("backpressure");
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] dig;
    int lat, n;
    logic ok, seen;
    in_block = BLK_ABC;
    in_first = 1'b1;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_digest !== 256'h0) begin
      errors++;
      $display("FAIL midrun_reset out_valid=%b in_ready=%b digest=%h expected 0 0 0", out_valid, in_ready, out_digest);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL aborted_no_output out_valid_seen=%b expected 0", seen); end
    send_block(BLK_ABC, 1'b0, 1'b0, dig, lat, ok);
    if (ok) begin
      checks++;
      if (dig !== D_ABC) begin errors++; $display("FAIL after_reset_abc got %h expected %h", dig, D_ABC); end
      release_digest("after_reset");
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] dig;
    int lat;
    logic ok;
    send_block(BLK_ABC, 1'b1, 1'b1, dig, lat, ok);
    if (ok) begin
      checks++;
      if (dig !== D_ABC) begin errors++; $display("FAIL b2b_first got %h expected %h", dig, D_ABC); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept in_ready=%b expected 0", in_ready); end
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 500) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== ROUNDS + 1 || out_digest !== D_ABC) begin
        errors++;
        $display("FAIL b2b_second lat=%0d digest=%h expected %0d %h", lat, out_digest, ROUNDS + 1, D_ABC);
      end
      release_digest("b2b");
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [511:0] blk;
    logic [255:0] dig, exp_d, m_hash, base;
    logic first, ok;
    int lat;
    m_hash = IV;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom();
      first = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef SHA256_CHAIN_EN
      base = first ? IV : m_hash;
`else
      base = IV;
`endif
      exp_d  = ref_compress(base, blk);
      m_hash = exp_d;
      send_block(blk, first, 1'b0, dig, lat, ok);
      if (ok) begin
        checks++;
        if (dig !== exp_d || lat !== ROUNDS + 1) begin
          errors++;
          $display("FAIL random_%0d first=%b lat=%0d digest=%h expected %0d %h", n, first, lat, dig, ROUNDS + 1, exp_d);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_digest !== exp_d) begin
          errors++;
          $display("FAIL random_hold_%0d out_valid=%b digest=%h expected 1 %h", n, out_valid, out_digest, exp_d);
        end
        release_digest("random");
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_answers();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_iter_ctrl.md
Name: sha256_iter_ctrl

Overview:
- Sequencer that drives one external single-round SHA-256 datapath through 64 iterations per 512-bit block.
- The datapath has one registered stage per round: state a..h plus a 16-word message window, with W[t] in the top word.
- The block supplies the initial or chained hash, the Kt constant and the message window each round, feeds the round outputs back, performs the final digest addition and presents the digest over a valid/ready handshake.
- It sits between the block-feeder logic and the round datapath.

Parameters:
ROUNDS, 64, rounds per block; legal 1..64; anything other than 64 is for reduced-round debug only and is non-compliant.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  block offered
in_ready  out  1  block accepted when in_valid & in_ready at clk edge
in_block  in  512  padded block; W0 = bits 511:480, W15 = bits 31:0
in_first  in  1  sampled with block: 1 = start from IV, 0 = chain from previous digest
out_valid  out  1  digest available
out_ready  in  1  digest consumed when out_valid & out_ready
out_digest  out  256  H0 in bits 255:224 … H7 in bits 31:0
rnd_state_in  out  256  to datapath {a,b,c,d,e,f,g,h}, a in MSBs
rnd_kt  out  32  K[cnt] to datapath
rnd_msg_in  out  512  message window to datapath
rnd_state_out  in  256  registered datapath state output, same packing
rnd_msg_out  in  512  registered datapath window output

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, out_valid=0, out_digest=0.
  - hash_reg=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Block and base registers cleared. in_ready=0 while rst_n=0.
- FSM states: IDLE, RUN, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On handshake: capture in_block to blk_reg; capture base = in_first ? IV : hash_reg; cnt=0; go to RUN.
- RUN:
  - in_ready=0.
  - cnt==0: rnd_state_in=base, rnd_msg_in=blk_reg.
  - cnt>0: rnd_state_in=rnd_state_out, rnd_msg_in=rnd_msg_out.
  - rnd_kt=K[cnt] (standard 64-entry FIPS 180-4 table, internal ROM).
  - cnt increments each edge. At the edge where cnt==ROUNDS-1, go to ADD.
- ADD:
  - rnd_state_out holds the state after ROUNDS rounds.
  - At the edge: out_digest[i] = base[i] + state[i], per 32-bit word mod 2^32, no carry between words.
  - Load hash_reg with the same value; out_valid=1; go to DONE.
- DONE:
  - out_valid=1; out_digest held stable.
  - On out_ready: out_valid=0, go to IDLE. Same-cycle input acceptance is not allowed, because in_ready is low in DONE.
- Latency:
  - Handshake edge E0; out_valid rises after edge E0+ROUNDS+1, which is E65 for ROUNDS=64.
  - Minimum block-to-block period is ROUNDS+3 cycles.
- rnd_* outputs are don't-care in IDLE, ADD and DONE. The datapath result is ignored in those states.
- in_block and in_first changes after the handshake have no effect.
- Reset mid-RUN or mid-DONE aborts: no digest is output, and chaining restarts from IV.
- out_valid falls only on handshake or reset.

Optional Feature:
- Macro SHA256_CHAIN_EN.
- Defined: in_first honoured and hash_reg chaining active, giving multi-block messages.
- Undefined: in_first ignored, base is always IV, hash_reg not implemented; every block is hashed as a standalone single-block message.

Test Plan:
- "abc": in_block=61626380 000…000 00000018, in_first=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid rising exactly 65 cycles after accept.
- Empty message: in_block=80000000 then zeros, in_first=1 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first block in_first=1, second block in_first=0, length 0x1c0) -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Without SHA256_CHAIN_EN, the second digest must differ.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> digest stable, in_ready=0 throughout; out_ready=1 for one cycle -> out_valid=0 and in_ready=1 the next cycle.
- Reset mid-operation: pulse rst_n low at cnt=30 -> all outputs at reset values immediately (async), no out_valid. Then "abc" with in_first=0 -> IV-based correct digest.
- Back-to-back: in_valid held high with two "abc" blocks -> second accept occurs exactly one cycle after the first out_ready handshake, and both digests are correct.
